// File: rtl/div_sequencer.sv
// div_sequencer: iterative restoring divider controller for DIV/MOD, one quotient bit per cycle.
// Define DIV_SEQ_SIGNED_EN for two's-complement signed operation; otherwise operands are unsigned.
`default_nettype none

module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             isDiv,
    input  logic             isMod,
    input  logic             flush,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             divByZero
);

    localparam int       CW     = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [CW-1:0]    r_cnt;
    logic             r_mod;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_bmag;

    logic             w_accept;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_dvd_nx;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    assign w_accept = start && (isDiv || isMod) && !flush &&
                      ((r_state == S_IDLE) || (r_state == S_DONE));

    // One restoring step; the borrow of the WIDTH+1-bit subtraction is the compare.
    assign w_rem_sh = {r_rem, r_dvd[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_bmag};
    assign w_ge     = ~w_diff[WIDTH];
    assign w_rem_nx = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_dvd_nx = {r_dvd[WIDTH-2:0], w_ge};

`ifdef DIV_SEQ_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;

    assign w_a_mag   = A[WIDTH-1] ? -A : A;
    assign w_b_mag   = B[WIDTH-1] ? -B : B;
    assign w_quo_fix = r_neg_q ? -w_dvd_nx : w_dvd_nx;
    assign w_rem_fix = r_neg_r ? -w_rem_nx : w_rem_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
            r_neg_r <= A[WIDTH-1];
        end
    end
`else
    assign w_a_mag   = A;
    assign w_b_mag   = B;
    assign w_quo_fix = w_dvd_nx;
    assign w_rem_fix = w_rem_nx;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_RUN: begin
                if (flush)
                    w_next = S_IDLE;
                else if (r_cnt == '0)
                    w_next = S_DONE;
                else
                    w_next = S_RUN;
            end
            default: begin
                if (w_accept)
                    w_next = (B == '0) ? S_DONE : S_RUN;
            end
        endcase
    end

    always_comb begin
        busy = (r_state == S_RUN);
        done = (r_state == S_DONE);
    end

    // Result and divByZero change only on entry to DONE; a flush leaves them untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_mod     <= 1'b0;
            r_dvd     <= '0;
            r_rem     <= '0;
            r_bmag    <= '0;
            result    <= '0;
            divByZero <= 1'b0;
        end else if (w_accept) begin
            r_cnt  <= CW'(WIDTH - 1);
            r_mod  <= isMod;
            r_dvd  <= w_a_mag;
            r_rem  <= '0;
            r_bmag <= w_b_mag;
            if (B == '0) begin
                result    <= isMod ? A : '1;
                divByZero <= 1'b1;
            end
        end else if ((r_state == S_RUN) && !flush) begin
            r_dvd <= w_dvd_nx;
            r_rem <= w_rem_nx;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == '0) begin
                result    <= r_mod ? w_rem_fix : w_quo_fix;
                divByZero <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
